// File: rtl/ecc16_enc_arbiter_pkg.sv
// Shared constants and types for the round-robin ECC16 encoder arbiter.
package ecc16_enc_arbiter_pkg;

  localparam int ECC_DATA_W = 16;
  localparam int ECC_PAR_W  = 6;
  localparam int DEF_NREQ   = 4;
  localparam int CNT_W      = 16;

  // Data-bit selection masks for check bits p0..p4
  localparam logic [ECC_DATA_W-1:0] P0_MASK = 16'hAD5B;
  localparam logic [ECC_DATA_W-1:0] P1_MASK = 16'h366D;
  localparam logic [ECC_DATA_W-1:0] P2_MASK = 16'hC78E;
  localparam logic [ECC_DATA_W-1:0] P3_MASK = 16'h07F0;
  localparam logic [ECC_DATA_W-1:0] P4_MASK = 16'hF800;

  typedef logic [ECC_DATA_W-1:0] eccData_t;
  typedef logic [ECC_PAR_W-1:0]  eccPar_t;
  typedef logic [CNT_W-1:0]      wordCnt_t;

endpackage

// File: rtl/ecc16_enc_arbiter_if.sv
// Requester, output-stage and control bundle of the ECC16 encoder arbiter.
interface ecc16_enc_arbiter_if
  import ecc16_enc_arbiter_pkg::*;
  #(parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(DEF_NREQ))
  ();

  logic [NREQ-1:0]            req_valid;
  logic [ECC_DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       out_valid;
  logic                       out_ready;
  eccData_t                   out_data;
  eccPar_t                    out_parity;
  logic [IDW-1:0]             out_id;
  logic                       inject_err;
  logic                       count_clr;
  wordCnt_t                   word_count;

  modport master (
    output req_valid, req_data, out_ready, inject_err, count_clr,
    input  req_ready, out_valid, out_data, out_parity, out_id, word_count
  );

  modport slave (
    input  req_valid, req_data, out_ready, inject_err, count_clr,
    output req_ready, out_valid, out_data, out_parity, out_id, word_count
  );

endinterface

// File: rtl/ecc16_enc_arbiter_encoder.sv
// 16-data / 6-check-bit ECC encoder, purely combinational.
module ecc16_encoder
  import ecc16_enc_arbiter_pkg::*;
  (
    input  eccData_t data_i,
    output eccPar_t  parity_o
  );

  logic [4:0] partial;

  // p0..p4 are masked XOR reductions; p5 covers all data bits plus p0..p4
  always_comb begin
    partial[0] = ^(data_i & P0_MASK);
    partial[1] = ^(data_i & P1_MASK);
    partial[2] = ^(data_i & P2_MASK);
    partial[3] = ^(data_i & P3_MASK);
    partial[4] = ^(data_i & P4_MASK);
    parity_o   = {(^data_i) ^ (^partial), partial};
  end

endmodule

// File: rtl/ecc16_enc_arbiter.sv
// Round-robin arbiter sharing one ECC16 encoder among NREQ requesters,
// with a single-entry output stage, one-shot error injection and a
// saturating handshake counter.
module ecc16_enc_arbiter
  import ecc16_enc_arbiter_pkg::*;
  #(parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(DEF_NREQ))
  (
    input logic clock,
    input logic reset_n,
    ecc16_enc_arbiter_if.slave bus
  );

  logic            load;
  logic            anyGrant;
  logic [IDW-1:0]  grantIdx;
  logic [IDW-1:0]  candIdx;
  logic [NREQ-1:0] grantOneHot;
  eccData_t        grantData;
  eccPar_t         grantParity;

  logic           outValid_q,  outValid_d;
  eccData_t       outData_q,   outData_d;
  eccPar_t        outParity_q, outParity_d;
  logic [IDW-1:0] outId_q,     outId_d;
  logic [IDW-1:0] rrPtr_q,     rrPtr_d;
  logic           errArmed_q,  errArmed_d;
  wordCnt_t       wordCount_q, wordCount_d;

  assign load = !outValid_q || bus.out_ready;

  // Search for the first valid requester starting at rrPtr_q, wrapping round
  always_comb begin
    anyGrant = 1'b0;
    grantIdx = '0;
    candIdx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      candIdx = IDW'((int'(rrPtr_q) + k) % NREQ);
      if (!anyGrant && bus.req_valid[candIdx]) begin
        anyGrant = 1'b1;
        grantIdx = candIdx;
      end
    end
    if (!load) begin
      anyGrant = 1'b0;
    end
  end

  // One-hot accept towards the winner, only when the output stage can load
  always_comb begin
    grantOneHot = '0;
    if (anyGrant) begin
      grantOneHot[grantIdx] = 1'b1;
    end
  end

  assign grantData = bus.req_data[ECC_DATA_W*int'(grantIdx) +: ECC_DATA_W];

  ecc16_encoder uEncoder (
    .data_i   (grantData),
    .parity_o (grantParity)
  );

  // Output stage, pointer and injection next state; parity sees clean data
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outParity_d = outParity_q;
    outId_d     = outId_q;
    rrPtr_d     = rrPtr_q;
    errArmed_d  = errArmed_q;
    if (load) begin
      if (anyGrant) begin
        outValid_d  = 1'b1;
        outData_d   = grantData ^ {{(ECC_DATA_W-1){1'b0}}, errArmed_q};
        outParity_d = grantParity;
        outId_d     = grantIdx;
        rrPtr_d     = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + IDW'(1);
      end else begin
        outValid_d  = 1'b0;
      end
    end
    if (anyGrant && errArmed_q) begin
      errArmed_d = bus.inject_err;
    end else if (bus.inject_err) begin
      errArmed_d = 1'b1;
    end
  end

  // Handshake counter: clear wins, otherwise count and stick at all-ones
  always_comb begin
    wordCount_d = wordCount_q;
    if (bus.count_clr) begin
      wordCount_d = '0;
    end else if (outValid_q && bus.out_ready && (wordCount_q != '1)) begin
      wordCount_d = wordCount_q + CNT_W'(1);
    end
  end

  // State registers with immediate asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outParity_q <= '0;
      outId_q     <= '0;
      rrPtr_q     <= '0;
      errArmed_q  <= 1'b0;
      wordCount_q <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outParity_q <= outParity_d;
      outId_q     <= outId_d;
      rrPtr_q     <= rrPtr_d;
      errArmed_q  <= errArmed_d;
      wordCount_q <= wordCount_d;
    end
  end

  assign bus.req_ready  = grantOneHot;
  assign bus.out_valid  = outValid_q;
  assign bus.out_data   = outData_q;
  assign bus.out_parity = outParity_q;
  assign bus.out_id     = outId_q;
  assign bus.word_count = wordCount_q;

endmodule

// File: tb/tb_ecc16_enc_arbiter.sv
// Randomised scoreboard bench for ecc16_enc_arbiter against a reference model.
module tb_ecc16_enc_arbiter;
  import ecc16_enc_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [15:0]    data;
    logic [5:0]     parity;
    logic [IDW-1:0] id;
  } expWord_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic running = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  expWord_t expQ[$];

  int mPtr;
  bit mArmed;
  bit mOutValid;
  int mCount;

  always #5 clock = ~clock;

  ecc16_enc_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  ecc16_enc_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Check bits straight from the equation lists, one data bit at a time
  function automatic logic [5:0] refParity(input logic [15:0] d);
    int l0[10];
    int l1[9];
    int l2[9];
    logic [5:0] p;
    l0 = '{0, 1, 3, 4, 6, 8, 10, 11, 13, 15};
    l1 = '{0, 2, 3, 5, 6, 9, 10, 12, 13};
    l2 = '{1, 2, 3, 7, 8, 9, 10, 14, 15};
    p = '0;
    foreach (l0[k]) p[0] = p[0] ^ d[l0[k]];
    foreach (l1[k]) p[1] = p[1] ^ d[l1[k]];
    foreach (l2[k]) p[2] = p[2] ^ d[l2[k]];
    for (int i = 4; i <= 10; i++) p[3] = p[3] ^ d[i];
    for (int i = 11; i <= 15; i++) p[4] = p[4] ^ d[i];
    for (int i = 0; i < 16; i++) p[5] = p[5] ^ d[i];
    for (int i = 0; i < 5; i++) p[5] = p[5] ^ p[i];
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus, driven just after the rising edge
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [16*NREQ-1:0] d,
                               input logic rdy, input logic inj, input logic clr);
    @(posedge clock);
    #1;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.out_ready  = rdy;
    bus.inject_err = inj;
    bus.count_clr  = clr;
  endtask

  task automatic doReset();
    reset_n        = 1'b0;
    running        = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.out_ready  = 1'b0;
    bus.inject_err = 1'b0;
    bus.count_clr  = 1'b0;
    expQ.delete();
    mPtr      = 0;
    mArmed    = 1'b0;
    mOutValid = 1'b0;
    mCount    = 0;
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    running = 1'b1;
  endtask

  // Reference model: predicts grants, counter and pushes expected words
  always @(negedge clock) begin
    if (reset_n && running) begin
      bit load;
      int g;
      int idx;
      logic [15:0] d;
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mOutValid));
      checkOutput("word_count", 32'(bus.word_count), 32'(mCount));
      load = !mOutValid || bus.out_ready;
      g = -1;
      if (load) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (mPtr + k) % NREQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      checkOutput("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      if (bus.count_clr) mCount = 0;
      else if (mOutValid && bus.out_ready && mCount < 65535) mCount = mCount + 1;
      if (g >= 0) begin
        d = bus.req_data[16*g +: 16];
        expQ.push_back('{data: d ^ 16'(mArmed), parity: refParity(d), id: IDW'(g)});
        mPtr      = (g + 1) % NREQ;
        mOutValid = 1'b1;
      end else if (load) begin
        mOutValid = 1'b0;
      end
      if (g >= 0 && mArmed) mArmed = bus.inject_err;
      else if (bus.inject_err) mArmed = 1'b1;
    end
  end

  // Monitor: compares the presented word against the oldest expectation
  always @(negedge clock) begin
    if (reset_n && running && bus.out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 32'(bus.out_valid), 32'd0);
      end else begin
        checkOutput("out_data", 32'(bus.out_data), 32'(expQ[0].data));
        checkOutput("out_parity", 32'(bus.out_parity), 32'(expQ[0].parity));
        checkOutput("out_id", 32'(bus.out_id), 32'(expQ[0].id));
        if (bus.out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    logic [16*NREQ-1:0] rd;

    // Reset state and single-requester parity cases
    doReset();
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_out_parity", 32'(bus.out_parity), 32'd0);
    checkOutput("rst_out_id", 32'(bus.out_id), 32'd0);
    checkOutput("rst_word_count", 32'(bus.word_count), 32'd0);
    applyStimulus(4'b0001, 64'h0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 64'h0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 64'hFFFF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("p_ffff_direct", 32'(bus.out_parity), 32'h1E);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);

    // Rotation with all requesters, then with req1 dropped
    for (int i = 0; i < 6; i++) begin
      rd = {$urandom(), $urandom()};
      applyStimulus(4'b1111, rd, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      rd = {$urandom(), $urandom()};
      applyStimulus(4'b1101, rd, 1'b1, 1'b0, 1'b0);
    end

    // Backpressure for three clocks mid-stream
    for (int i = 0; i < 8; i++) begin
      rd = {$urandom(), $urandom()};
      applyStimulus(4'b1111, rd, (i < 2 || i > 4), 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);

    // Error injection then two words from req2
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0100, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0100, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("inj_second_clean", 32'(bus.out_data), 32'h0001);

    // Random traffic with stalls, injections and clears
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom(), $urandom()};
      applyStimulus(4'($urandom()), rd, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
    end

    // Counter: 100 handshakes, clear during a handshake, then saturation
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      rd = {$urandom(), $urandom()};
      applyStimulus(4'b0001, rd, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("count_100", 32'(bus.word_count), 32'd100);
    applyStimulus(4'b0001, 64'h1234, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("count_clr_hs", 32'(bus.word_count), 32'd0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 65538; i++) begin
      rd = {$urandom(), $urandom()};
      applyStimulus(4'b1111, rd, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("count_saturated", 32'(bus.word_count), 32'hFFFF);

    // Asynchronous reset while a word is stalled in the output stage
    applyStimulus(4'b1111, 64'h5555_AAAA_1234_8765, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1111, 64'h5555_AAAA_1234_8765, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #3;
    running = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_word_count", 32'(bus.word_count), 32'd0);
    checkOutput("async_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("async_out_parity", 32'(bus.out_parity), 32'd0);
    checkOutput("async_out_id", 32'(bus.out_id), 32'd0);
    doReset();
    applyStimulus(4'b1111, {$urandom(), $urandom()}, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("post_rst_id", 32'(bus.out_id), 32'd0);

    // Drain and confirm nothing outstanding
    repeat (3) applyStimulus(4'b0000, 64'h0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc16_enc_arbiter.md
Name: ecc16_enc_arbiter

Overview:
Round-robin arbiter that shares one 16-data/6-parity ECC encoder among NREQ requesters in the ALCT path.
Each requester offers a 16-bit word with a valid/ready handshake. The winning word is encoded and registered into a single-entry output stage, together with its source id.
The block also provides a one-shot error-injection self-test and a handshake word counter.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, id width; must equal clog2(NREQ)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester word valid
req_data  in  16*NREQ  requester i data on bits [16*i+15:16*i]
req_ready  out  NREQ  one-hot grant/accept, combinational
out_valid  out  1  output stage holds a word
out_ready  in  1  downstream accepts output
out_data  out  16  encoded data word
out_parity  out  6  ECC check bits of the original data
out_id  out  IDW  source requester of the output word
inject_err  in  1  arms a single-word data corruption
count_clr  in  1  clears word_count
word_count  out  16  saturating count of output handshakes

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_data=0, out_parity=0, out_id=0, rr_ptr=0, err_armed=0, word_count=0. Effect is immediate, including mid-transfer; the held word is discarded.
- load = !out_valid | (out_valid & out_ready). Accept is allowed only when load=1.
- Grant: when load=1 and any req_valid is set, g = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... and wrapping NREQ-1 -> 0.
  - req_ready[g]=1 for that cycle only; all other req_ready bits are 0.
  - When load=0, req_ready is all 0.
- On grant, registered on the next edge:
  - out_data = req_data[g] ^ {15'b0, err_armed}
  - out_parity = encoder(req_data[g]); parity always uses the uncorrupted data
  - out_id = g, out_valid = 1
  - rr_ptr = (g+1) mod NREQ
- Latency: 1 clock from req handshake to out_valid. Full throughput is one word per clock with out_ready held high.
- load=1 with no req_valid: out_valid=0 on the next edge. out_data/out_parity/out_id keep their last values.
- Backpressure (out_valid=1, out_ready=0): all outputs are held stable, no grant is issued, and rr_ptr is unchanged.
- Parity equations, where "+" denotes XOR and dN = req_data bit N:
  - p0 = d0+d1+d3+d4+d6+d8+d10+d11+d13+d15
  - p1 = d0+d2+d3+d5+d6+d9+d10+d12+d13
  - p2 = d1+d2+d3+d7+d8+d9+d10+d14+d15
  - p3 = d4..d10
  - p4 = d11..d15
  - p5 = XOR of all 16 data bits and p0..p4
- Error injection:
  - inject_err=1 sets err_armed on the next edge.
  - A grant in the same cycle that inject_err is sampled uses the old err_armed value.
  - err_armed clears on the edge that loads the corrupted word.
  - inject_err while already armed: no additional effect.
  - If inject_err and a grant with err_armed=1 coincide, err_armed stays set, so the next word is also corrupted.
- word_count:
  - count_clr=1 sets it to 0; clear has priority over increment.
  - Otherwise it increments on out_valid & out_ready and saturates at 16'hFFFF.

Decomposition:
- Shared package: ECC_DATA_W=16, ECC_PAR_W=6, default NREQ=4, CNT_W=16.
- One sub-module, ecc16_encoder, instantiated once. Its input is the grant mux output and its output feeds the out_parity register.
- The arbiter priority search and the rr_ptr register stay inline.

Test Plan:
1. Req0 only, out_ready=1, data 0x0000 / 0x0001 / 0xFFFF -> out_valid one clock later; parity 0x00 / 0x23 / 0x1E; out_id=0.
2. All four req_valid held high, out_ready=1 -> out_id sequence 0,1,2,3,0,1 with one word per clock. Then drop req1 -> sequence skips to 2 after 0.
3. Stream active, out_ready low for 3 clocks -> out_data, out_parity, out_id frozen; req_ready all 0; no words lost or duplicated after release.
4. inject_err pulse, then req2 data 0x0001 -> out_data 0x0000, out_parity 0x23, out_id 2. Next word 0x0001 -> out_data 0x0001, uncorrupted.
5. Preload 100 handshakes -> word_count=100. Assert count_clr during a handshake -> word_count=0. Force 0xFFFF then one more handshake -> remains 0xFFFF.
6. Assert reset_n low mid-stall with out_valid=1 -> out_valid, word_count and outputs go to 0 without waiting for a clock edge. After release, the first grant goes to req0.
